// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the ram_arbiter slice: FSM states, grant values and default widths.
package ram_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between ports A and B. RAM_ARB_RR_EN selects round-robin on ties
// (the port not granted most recently wins); otherwise A always beats B.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic   a_req,
  input  logic   b_req,
`ifdef RAM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output grant_t grant
);

  always_comb begin
    grant = GNT_A;
`ifdef RAM_ARB_RR_EN
    if (a_req && b_req) begin
      if (last_grant == GNT_A) grant = GNT_B;
      else                     grant = GNT_A;
    end else if (b_req) begin
      grant = GNT_B;
    end
`else
    if (!a_req && b_req) grant = GNT_B;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM with RD_LATENCY-cycle
// registered read data. Optional macro RAM_ARB_RR_EN enables round-robin tie breaking.
//
// state    | meaning
// ST_IDLE  | sample requests, latch the winner's command
// ST_ISSUE | drive the latched command to the RAM for one cycle
// ST_WAIT  | count down the RAM read latency, capture ram_dout on the last cycle
// ST_DONE  | pulse the winner's done
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_t        state, nxt_state;
  grant_t        grant, pick;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [1:0]    cnt;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          any_req;

  assign any_req = a_req | b_req;

`ifdef RAM_ARB_RR_EN
  grant_t last_grant;

  always_ff @(posedge clk) begin
    if (rst)                              last_grant <= GNT_A;
    else if (state == ST_IDLE && any_req) last_grant <= pick;
  end

  ram_arb_pick u_pick (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_grant (last_grant),
    .grant      (pick)
  );
`else
  ram_arb_pick u_pick (
    .a_req (a_req),
    .b_req (b_req),
    .grant (pick)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (any_req) nxt_state = ST_ISSUE;
      ST_ISSUE: nxt_state = lat_we ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (cnt == 2'd0) nxt_state = ST_DONE;
      ST_DONE:  nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // Command registers; lat_addr keeps driving the RAM after ISSUE so ram_dout stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= GNT_A;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= 2'd0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          grant     <= pick;
          lat_we    <= (pick == GNT_B) ? b_we    : a_we;
          lat_addr  <= (pick == GNT_B) ? b_addr  : a_addr;
          lat_wdata <= (pick == GNT_B) ? b_wdata : a_wdata;
        end
        ST_ISSUE: cnt <= CNT_INIT;
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            if (grant == GNT_B) b_rdata_q <= ram_dout;
            else                a_rdata_q <= ram_dout;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_done = (state == ST_DONE) && (grant == GNT_A);
    b_done = (state == ST_DONE) && (grant == GNT_B);
    ram_we = (state == ST_ISSUE) && lat_we;
  end

  assign ram_addr = lat_addr;
  assign ram_din  = lat_wdata;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at RD_LATENCY=1 and one at RD_LATENCY=2,
// each beside a behavioural 256x16 RAM with matching read latency.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [7:0]  a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic        a_done, b_done, ram_we;
  logic [15:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  logic        a2_req = 0, a2_we = 0, b2_req = 0, b2_we = 0;
  logic [7:0]  a2_addr = 0, b2_addr = 0;
  logic [15:0] a2_wdata = 0, b2_wdata = 0;
  logic        a2_done, b2_done, ram_we2;
  logic [15:0] a2_rdata, b2_rdata, ram_din2, ram_dout2;
  logic [7:0]  ram_addr2;

  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] d1, p1, p2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(16), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  ram_arbiter #(.AW(8), .DW(16), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .a_req(a2_req), .a_we(a2_we), .a_addr(a2_addr), .a_wdata(a2_wdata),
    .a_done(a2_done), .a_rdata(a2_rdata),
    .b_req(b2_req), .b_we(b2_we), .b_addr(b2_addr), .b_wdata(b2_wdata),
    .b_done(b2_done), .b_rdata(b2_rdata),
    .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_we(ram_we2), .ram_dout(ram_dout2)
  );

  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr] <= ram_din;
    d1 <= mem1[ram_addr];
    if (ram_we2) mem2[ram_addr2] <= ram_din2;
    p1 <= mem2[ram_addr2];
    p2 <= p1;
  end
  assign ram_dout  = d1;
  assign ram_dout2 = p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on dut; lat counts cycles from T0 to the done cycle.
  task automatic run(input bit pb, input bit we, input logic [7:0] addr, input logic [15:0] wd,
                     output int lat, output int wec);
    if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    lat = 0; wec = 0;
    while (!(a_done || b_done) && lat < 20) begin
      if (ram_we) wec++;
      tick();
      lat++;
    end
    if (pb) b_req = 0; else a_req = 0;
    tick();
  endtask

  task automatic run2(input bit we, input logic [7:0] addr, input logic [15:0] wd, output int lat);
    b2_req = 1; b2_we = we; b2_addr = addr; b2_wdata = wd;
    lat = 0;
    while (!b2_done && lat < 20) begin
      tick();
      lat++;
    end
    b2_req = 0;
    tick();
  endtask

  initial begin
    int lat, wec, n;
    logic [15:0] brd0, ard0;
    logic who;

    tick(); tick();
    rst = 0;
    check("rst_a_done", a_done, 0);
    check("rst_b_done", b_done, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);

    run(0, 1, 8'h12, 16'hBEEF, lat, wec);
    check("wr_lat", lat, 2);
    check("wr_we_cycles", wec, 1);
    check("wr_mem", mem1[8'h12], 16'hBEEF);
    run(0, 0, 8'h12, 16'h0000, lat, wec);
    check("rd_lat", lat, 3);
    check("rd_we_cycles", wec, 0);
    check("rd_data", a_rdata, 16'hBEEF);
    run(0, 1, 8'h01, 16'h1111, lat, wec);
    run(1, 1, 8'h02, 16'h2222, lat, wec);
    check("b_wr_lat", lat, 2);
    check("b_wr_mem", mem1[8'h02], 16'h2222);

    // Simultaneous requests from a fresh reset.
    rst = 1; tick(); rst = 0;
    a_req = 1; a_we = 0; a_addr = 8'h01;
    b_req = 1; b_we = 0; b_addr = 8'h02;
    brd0 = b_rdata; ard0 = a_rdata;
    n = 0;
    while (!a_done && !b_done && n < 20) begin tick(); n++; end
    check("tie_lat1", n, 3);
`ifdef RAM_ARB_RR_EN
    check("tie_first_b", b_done, 1);
    check("tie_b_data", b_rdata, 16'h2222);
    check("tie_a_hold", a_rdata, ard0);
    b_req = 0;
`else
    check("tie_first_a", a_done, 1);
    check("tie_a_data", a_rdata, 16'h1111);
    check("tie_b_hold", b_rdata, brd0);
    a_req = 0;
`endif
    tick();
    n = 0;
    while (!a_done && !b_done && n < 20) begin tick(); n++; end
    check("tie_lat2", n, 3);
`ifdef RAM_ARB_RR_EN
    check("tie_second_a", a_done, 1);
`else
    check("tie_second_b", b_done, 1);
`endif
    check("tie_a_final", a_rdata, 16'h1111);
    check("tie_b_final", b_rdata, 16'h2222);
    a_req = 0; b_req = 0;
    tick();

    // Back-to-back reads with both requests held.
    a_req = 1; a_we = 0; a_addr = 8'h01;
    b_req = 1; b_we = 0; b_addr = 8'h02;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!a_done && !b_done && n < 20) begin tick(); n++; end
      check("b2b_spacing", n, 3);
      who = b_done;
`ifdef RAM_ARB_RR_EN
      check("b2b_rr_order", who, (k % 2 == 0) ? 1 : 0);
`else
      check("b2b_fixed_a", who, 0);
`endif
      if (who) check("b2b_b_data", b_rdata, 16'h2222);
      else     check("b2b_a_data", a_rdata, 16'h1111);
      tick();
    end
    a_req = 0; b_req = 0;
    tick(); tick(); tick(); tick();

    // Reset in the WAIT cycle of a B read, with A requesting.
    b_req = 1; b_we = 0; b_addr = 8'h02;
    tick(); tick();
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 8'h12;
    rst = 1;
    tick();
    check("mid_rst_b_done", b_done, 0);
    check("mid_rst_a_done", a_done, 0);
    check("mid_rst_b_rdata", b_rdata, 0);
    check("mid_rst_ram_we", ram_we, 0);
    check("mid_rst_ram_addr", ram_addr, 0);
    rst = 0;
    run(0, 0, 8'h12, 16'h0000, lat, wec);
    check("post_rst_lat", lat, 3);
    check("post_rst_data", a_rdata, 16'hBEEF);

    // Request changes after acceptance are ignored.
    b_req = 1; b_we = 1; b_addr = 8'h30; b_wdata = 16'h1234;
    tick();
    b_addr = 8'h31; b_wdata = 16'hFFFF; b_we = 0;
    check("chg_ram_addr", ram_addr, 8'h30);
    check("chg_ram_din", ram_din, 16'h1234);
    check("chg_ram_we", ram_we, 1);
    tick();
    check("chg_done", b_done, 1);
    check("chg_we_off", ram_we, 0);
    b_req = 0;
    tick();
    check("chg_done_once", b_done, 0);
    check("chg_mem", mem1[8'h30], 16'h1234);
    b_req = 1; b_we = 0; b_addr = 8'h12;
    tick();
    b_addr = 8'h30;
    tick();
    check("chg_rd_addr", ram_addr, 8'h12);
    tick();
    check("chg_rd_done", b_done, 1);
    check("chg_rd_data", b_rdata, 16'hBEEF);
    b_req = 0;
    tick();

    // RD_LATENCY = 2 instance.
    run2(1, 8'hFF, 16'hA5A5, lat);
    check("l2_wr_lat", lat, 2);
    run2(0, 8'hFF, 16'h0000, lat);
    check("l2_rd_lat", lat, 4);
    check("l2_rd_data", b2_rdata, 16'hA5A5);
    run2(1, 8'h00, 16'h0F0F, lat);
    run2(0, 8'h00, 16'h0000, lat);
    check("l2_rd0_lat", lat, 4);
    check("l2_rd0_data", b2_rdata, 16'h0F0F);
    check("l2_a_untouched", a2_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
